otter_hazard_ctrl: RTL
======================

Name: otter_hazard_ctrl

Overview:
Parametrised hazard, forwarding and stall/flush controller for the 5-stage OTTER pipeline (IF, DE, EX, MEM, WB). It keeps its own scoreboard of in-flight destination registers, so the pipeline registers need no extra tracking. From the scoreboard it produces PC/pipeline-register enables, bubble/flush controls and operand-forwarding selects. It sits beside the decode stage and replaces the fixed always-write PC/IF-DE enables and the always-on memory read enable.

Parameters:
REG_ADDR_W, 5, width of register addresses.
FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = stall-only mode with no forwarding.
CNT_W, 16, width of the saturating stall and flush performance counters.
MEM_TIMEOUT, 255, maximum consecutive mem_busy cycles before mem_timeout is set.

Ports:
CPU_CLK  in  1  clock, rising edge.
CPU_RST_N  in  1  asynchronous active-low reset.
de_valid  in  1  DE stage holds a real instruction.
de_rs1_addr  in  REG_ADDR_W  rs1 field of the DE instruction.
de_rs2_addr  in  REG_ADDR_W  rs2 field of the DE instruction.
de_rs1_used, de_rs2_used  in  1 each  DE instruction reads the operand (already 0 when the address is x0).
de_rd_addr  in  REG_ADDR_W  rd field of the DE instruction.
de_reg_write  in  1  DE instruction writes rd.
de_is_load  in  1  DE instruction is a LOAD.
ex_taken  in  1  EX instruction redirects the PC (pcSource != 0).
mem_busy  in  1  data memory not ready; the pipeline must freeze.
pc_we  out  1  PC write enable.
if_de_we  out  1  IF/DE register (and instruction read enable) write enable.
de_flush  out  1  IF/DE register loads a NOP on the next edge.
ex_bubble  out  1  DE/EX register loads a NOP (control bits cleared).
pipe_we  out  1  DE/EX, EX/MEM and MEM/WB register enable.
fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 EX ALU result, 10 MEM stage result, 11 WB write data.
stall_count, flush_count  out  CNT_W each  saturating counters.
mem_timeout  out  1  sticky error flag.

Behaviour:
- Scoreboard: three slots (EX, MEM, WB), each holding {valid, rd, reg_write, is_load}. A slot counts for hazards only if valid, reg_write and rd != 0.
- When pipe_we=1, slots shift on the clock edge: DE→EX, EX→MEM, MEM→WB. The EX slot loads invalid whenever ex_bubble=1.
- FSM states: RUN, FREEZE.
- RUN→FREEZE when mem_busy=1. FREEZE→RUN on the first cycle with mem_busy=0.
- In FREEZE: pc_we, if_de_we and pipe_we are all 0; ex_taken and hazards are ignored; all slots hold. A branch held in EX resolves after the freeze ends.
- Priority in RUN: taken branch > load-use/RAW stall > normal.
- Taken branch: de_flush=1 and ex_bubble=1; pc_we=1, if_de_we=1, pipe_we=1. This kills the two younger instructions. flush_count increments by 1.
- Hazard match means (rs1_used and rs1==slot.rd) or (rs2_used and rs2==slot.rd), with de_valid=1.
- FWD_EN=1: stall when the EX slot is a load and matches, or the MEM slot is a load and matches. Load data is usable only from WB.
- FWD_EN=0: stall on any match against EX, MEM or WB.
- Stall: pc_we=0, if_de_we=0, ex_bubble=1, pipe_we=1; stall_count increments by 1 per stalled cycle. A load-use against EX therefore lasts 2 cycles; against MEM, 1 cycle.
- Forwarding (FWD_EN=1, no stall): per operand, the youngest match wins, EX > MEM > WB. If there is no match, or FWD_EN=0, the select is 00.
- fwd_*_sel and the enables are combinational from the inputs and the registered slot/FSM state. They are 00/0 whenever the operand is unused.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Timeout: a wait counter increments each FREEZE cycle and clears in RUN. When it reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset; the freeze itself continues.
- Reset (asynchronous, any time including mid-freeze or mid-stall): FSM=RUN, all slots invalid, counters=0, wait counter=0, mem_timeout=0. Consequently, with de_valid=0 and mem_busy=0: pc_we=1, if_de_we=1, pipe_we=1, de_flush=0, ex_bubble=0, fwd selects=00.

Decomposition:
- Shared package otter_pkg holds: opcode_t (moved out of the MCU), the fwd_sel_t enum (FWD_RF, FWD_EX, FWD_MEM, FWD_WB), the hz_state_t enum (RUN, FREEZE), and the scoreboard slot struct.
- One sub-module: otter_hz_slot, a single scoreboard slot register with enable and clear, instantiated three times.

Test Plan:
- Reset, then de_valid=0 for 5 cycles -> pc_we=if_de_we=pipe_we=1, fwd=00, counters 0.
- ADDI x5 then ADD x6,x5,x5 (FWD_EN=1) -> fwd_a_sel=fwd_b_sel=01 for one cycle, no stall.
- LW x7 then ADD x8,x7,x0 -> 2 stall cycles (pc_we=0, ex_bubble=1), then fwd_a_sel=11; stall_count=2.
- Branch in EX with ex_taken=1, with a load-use hazard in DE in the same cycle -> de_flush=1, ex_bubble=1, pc_we=1, no stall; flush_count=1.
- mem_busy=1 for 3 cycles with ex_taken=1 held -> all enables 0 for 3 cycles, then flush on cycle 4. With MEM_TIMEOUT=2 -> mem_timeout=1 after the 2nd busy cycle and stays 1.
- FWD_EN=0, ADDI x5 followed by a dependent ADD -> 3 stall cycles, fwd=00. Assert CPU_RST_N=0 mid-stall -> enables immediately return to 1.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER types: opcodes, forwarding selects,
// hazard FSM states and the in-flight scoreboard slot.
package otter_pkg;

  localparam int OTTER_RA_W = 5;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                  valid;
    logic [OTTER_RA_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } hz_slot_t;

  // A slot only produces hazards if it will write a real register.
  function automatic logic slot_live(hz_slot_t s);
    return s.valid & s.reg_write & (s.rd != '0);
  endfunction

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// Decode-side hazard bundle: DE operand info, EX redirect, memory busy
// in; enables, flush/bubble, forwarding selects, counters, timeout out.
interface otter_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  import otter_pkg::*;

  logic                  de_valid;
  logic [REG_ADDR_W-1:0] de_rs1_addr;
  logic [REG_ADDR_W-1:0] de_rs2_addr;
  logic                  de_rs1_used;
  logic                  de_rs2_used;
  logic [REG_ADDR_W-1:0] de_rd_addr;
  logic                  de_reg_write;
  logic                  de_is_load;
  logic                  ex_taken;
  logic                  mem_busy;

  logic                  pc_we;
  logic                  if_de_we;
  logic                  de_flush;
  logic                  ex_bubble;
  logic                  pipe_we;
  fwd_sel_t              fwd_a_sel;
  fwd_sel_t              fwd_b_sel;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;
  logic                  mem_timeout;

  modport master (
    output de_valid, de_rs1_addr, de_rs2_addr,
    output de_rs1_used, de_rs2_used,
    output de_rd_addr, de_reg_write, de_is_load,
    output ex_taken, mem_busy,
    input  pc_we, if_de_we, de_flush, ex_bubble,
    input  pipe_we, fwd_a_sel, fwd_b_sel,
    input  stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  de_valid, de_rs1_addr, de_rs2_addr,
    input  de_rs1_used, de_rs2_used,
    input  de_rd_addr, de_reg_write, de_is_load,
    input  ex_taken, mem_busy,
    output pc_we, if_de_we, de_flush, ex_bubble,
    output pipe_we, fwd_a_sel, fwd_b_sel,
    output stall_count, flush_count, mem_timeout
  );

endinterface

// File: rtl/otter_hz_slot.sv
// One scoreboard slot register. Ports: clk_i, rst_ni, en_i (load),
// clr_i (load invalid instead of d_i), d_i, q_o.
module otter_hz_slot
  import otter_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     en_i,
  input  logic     clr_i,
  input  hz_slot_t d_i,
  output hz_slot_t q_o
);

  hz_slot_t q_q;
  hz_slot_t q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = clr_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER hazard/forwarding/stall controller. Ports: CPU_CLK, CPU_RST_N,
// hz (slave side of otter_hazard_ctrl_if).
module otter_hazard_ctrl
  import otter_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter bit FWD_EN      = 1'b1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                CPU_CLK,
  input logic                CPU_RST_N,
  otter_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX =
    WAIT_W'(MEM_TIMEOUT);

  hz_state_t state_q, state_d;

  hz_slot_t de_s;
  hz_slot_t ex_q;
  hz_slot_t mem_q;
  hz_slot_t wb_q;

  logic [REG_ADDR_W-1:0] rs1_raw;
  logic [REG_ADDR_W-1:0] rs2_raw;
  logic [REG_ADDR_W-1:0] rd_raw;
  logic [OTTER_RA_W-1:0] rs1;
  logic [OTTER_RA_W-1:0] rs2;

  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic m_ex, m_mem, m_wb;
  logic hazard;

  logic pc_we, if_de_we, pipe_we;
  logic de_flush, ex_bubble;
  logic stall_inc, flush_inc;
  fwd_sel_t fwd_a, fwd_b;

  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;

  assign rs1_raw = hz.de_rs1_addr;
  assign rs2_raw = hz.de_rs2_addr;
  assign rd_raw  = hz.de_rd_addr;
  assign rs1     = OTTER_RA_W'(rs1_raw);
  assign rs2     = OTTER_RA_W'(rs2_raw);

  function automatic logic hit(
    hz_slot_t              s,
    logic                  used,
    logic [OTTER_RA_W-1:0] a
  );
    return slot_live(s) & used & (a == s.rd);
  endfunction

  assign a_ex  = hz.de_valid & hit(ex_q,  hz.de_rs1_used, rs1);
  assign a_mem = hz.de_valid & hit(mem_q, hz.de_rs1_used, rs1);
  assign a_wb  = hz.de_valid & hit(wb_q,  hz.de_rs1_used, rs1);
  assign b_ex  = hz.de_valid & hit(ex_q,  hz.de_rs2_used, rs2);
  assign b_mem = hz.de_valid & hit(mem_q, hz.de_rs2_used, rs2);
  assign b_wb  = hz.de_valid & hit(wb_q,  hz.de_rs2_used, rs2);

  assign m_ex  = a_ex  | b_ex;
  assign m_mem = a_mem | b_mem;
  assign m_wb  = a_wb  | b_wb;

  // With forwarding only load data is late: it exists from WB on.
  // Without forwarding anything in flight must drain past WB.
  always_comb begin
    if (FWD_EN) begin
      hazard = (m_ex & ex_q.is_load) | (m_mem & mem_q.is_load);
    end else begin
      hazard = m_ex | m_mem | m_wb;
    end
  end

  // mem_busy freezes the pipe in the same cycle it is seen, so the
  // freeze lasts exactly as many cycles as mem_busy is high.
  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b1;
    if_de_we  = 1'b1;
    pipe_we   = 1'b1;
    de_flush  = 1'b0;
    ex_bubble = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      RUN:     if (hz.mem_busy)  state_d = FREEZE;
      FREEZE:  if (!hz.mem_busy) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (hz.mem_busy) begin
      pc_we    = 1'b0;
      if_de_we = 1'b0;
      pipe_we  = 1'b0;
    end else if (hz.ex_taken) begin
      de_flush  = 1'b1;
      ex_bubble = 1'b1;
      flush_inc = 1'b1;
    end else if (hazard) begin
      pc_we     = 1'b0;
      if_de_we  = 1'b0;
      ex_bubble = 1'b1;
      stall_inc = 1'b1;
    end
  end

  // Youngest producer wins.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN && !hazard) begin
      if (a_ex)       fwd_a = FWD_EX;
      else if (a_mem) fwd_a = FWD_MEM;
      else if (a_wb)  fwd_a = FWD_WB;
      if (b_ex)       fwd_b = FWD_EX;
      else if (b_mem) fwd_b = FWD_MEM;
      else if (b_wb)  fwd_b = FWD_WB;
    end
  end

  always_comb begin
    de_s = '{
      valid:     hz.de_valid,
      rd:        OTTER_RA_W'(rd_raw),
      reg_write: hz.de_reg_write,
      is_load:   hz.de_is_load
    };
  end

  otter_hz_slot u_ex (
    .clk_i  (CPU_CLK),
    .rst_ni (CPU_RST_N),
    .en_i   (pipe_we),
    .clr_i  (ex_bubble),
    .d_i    (de_s),
    .q_o    (ex_q)
  );

  otter_hz_slot u_mem (
    .clk_i  (CPU_CLK),
    .rst_ni (CPU_RST_N),
    .en_i   (pipe_we),
    .clr_i  (1'b0),
    .d_i    (ex_q),
    .q_o    (mem_q)
  );

  otter_hz_slot u_wb (
    .clk_i  (CPU_CLK),
    .rst_ni (CPU_RST_N),
    .en_i   (pipe_we),
    .clr_i  (1'b0),
    .d_i    (mem_q),
    .q_o    (wb_q)
  );

  // WB results are consumed straight from the regfile write port,
  // so the load flag is never needed at that depth.
  logic unused_wb_ld;
  assign unused_wb_ld = wb_q.is_load;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    wait_d  = '0;
    tmo_d   = tmo_q;
    if (stall_inc && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
    if (flush_inc && flush_q != '1) begin
      flush_d = flush_q + 1'b1;
    end
    if (hz.mem_busy) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
      if (wait_d == WAIT_MAX) begin
        tmo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.if_de_we    = if_de_we;
  assign hz.pipe_we     = pipe_we;
  assign hz.de_flush    = de_flush;
  assign hz.ex_bubble   = ex_bubble;
  assign hz.fwd_a_sel   = fwd_a;
  assign hz.fwd_b_sel   = fwd_b;
  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
  assign hz.mem_timeout = tmo_q;

endmodule
